// File: rtl/shared_unit_arbiter_if.sv
// shared_unit_arbiter_if: request/grant bundle between requesters and the shared-unit arbiter
interface shared_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
);
    logic [NREQ-1:0]  Req;
    logic [NREQ-1:0]  Lock;
    logic [NREQ-1:0]  Grant;
    logic [IDX_W-1:0] GrantIdx;
    logic             GrantValid;
    logic [7:0]       PreemptCnt;

    modport master (
        output Req, Lock,
        input  Grant, GrantIdx, GrantValid, PreemptCnt
    );

    modport slave (
        input  Req, Lock,
        output Grant, GrantIdx, GrantValid, PreemptCnt
    );
endinterface

// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: round-robin burst arbiter for the shared datapath unit; define ARB_TURNAROUND_EN for a dead cycle between owners
module shared_unit_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDX_W    = 2,
    parameter int HOLD_MAX = 8
) (
    input logic                 Clk,
    input logic                 Reset,
    shared_unit_arbiter_if.slave arb
);
`ifdef ARB_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             valid_q;

    logic [NREQ-1:0]  cand;
    logic             pick_ok;
    logic [IDX_W-1:0] pick_idx;
    logic [NREQ-1:0]  pick_oh;
    logic             in_grant, own_req, others, at_max, forced, release_now;

    assign in_grant    = state_q == GRANT;
    assign own_req     = arb.Req[idx_q];
    assign others      = |(arb.Req & ~grant_q);
    assign at_max      = hold_q == 8'(HOLD_MAX - 1);
    assign forced      = in_grant && own_req && at_max && !arb.Lock[idx_q] && others;
    assign release_now = in_grant && (!own_req || forced);
    // the owner is excluded while it holds the grant, so a release hands off to someone else
    assign cand        = in_grant ? arb.Req & ~grant_q : arb.Req;

    // scan last+1, last+2, ... with wrap; descending loop lets the nearest candidate win
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (cand[(int'(last_q) + i) % NREQ]) begin
                pick_ok  = 1'b1;
                pick_idx = IDX_W'((int'(last_q) + i) % NREQ);
                pick_oh  = '0;
                pick_oh[(int'(last_q) + i) % NREQ] = 1'b1;
            end
        end
    end

    // next-state: hold the burst, release (direct or via TURN), or arbitrate from idle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hold_d  = hold_q;
        pcnt_d  = (forced && pcnt_q != 8'hFF) ? pcnt_q + 8'd1 : pcnt_q;
        if (in_grant && !release_now) begin
            hold_d = at_max ? hold_q : hold_q + 8'd1;
        end
`ifdef ARB_TURNAROUND_EN
        else if (in_grant) begin
            state_d = TURN;
            grant_d = '0;
            hold_d  = '0;
        end
`endif
        else begin
            state_d = pick_ok ? GRANT : IDLE;
            grant_d = pick_ok ? pick_oh : '0;
            idx_d   = pick_ok ? pick_idx : idx_q;
            last_d  = pick_ok ? pick_idx : last_q;
            hold_d  = '0;
        end
    end

    // state and registered outputs; reset acts asynchronously even mid-grant
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            hold_q  <= '0;
            pcnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            pcnt_q  <= pcnt_d;
            valid_q <= |grant_d;
        end
    end

    assign arb.Grant      = grant_q;
    assign arb.GrantIdx   = idx_q;
    assign arb.GrantValid = valid_q;
    assign arb.PreemptCnt = pcnt_q;
endmodule

// File: doc/shared_unit_arbiter.md
Name: shared_unit_arbiter

Overview:
Round-robin arbiter that shares one instance of the team's clocked datapath unit (registered toggle bit plus 2-bit wrapping counter) between NREQ requesters. It issues a registered one-hot grant and index that drive the unit's input muxes. Grants are held for bounded bursts, and a preemption counter reports forced releases.

Parameters:
NREQ, 4, number of requesters (2..8)
IDX_W, 2, width of GrantIdx; 2**IDX_W >= NREQ
HOLD_MAX, 8, max grant cycles before forced release when others are waiting (2..255)

Ports:
Clk  input  1  clock, posedge active
Reset  input  1  asynchronous, active-high reset
Req  input  NREQ  request per requester, level
Lock  input  NREQ  owner asks to be exempt from forced release
Grant  output  NREQ  one-hot grant, registered
GrantIdx  output  IDX_W  index of current owner, registered
GrantValid  output  1  high when Grant is nonzero
PreemptCnt  output  8  count of forced releases, saturates at 255

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports Clk and Reset.
- Reset values: Grant=0, GrantIdx=0, GrantValid=0, PreemptCnt=0, HoldCnt=0, LastIdx=NREQ-1, state IDLE. Reset takes effect immediately at any point, including mid-grant.
- States: IDLE, GRANT, TURN (TURN exists only with the optional feature).
- IDLE:
  - If Req is nonzero, select the first set bit scanning LastIdx+1, LastIdx+2, ... with wrap modulo NREQ.
  - On the next edge: Grant = that bit, GrantIdx = its index, LastIdx = its index, HoldCnt = 0, state = GRANT.
  - Latency from Req rising to Grant high is 1 cycle.
- GRANT (owner = GrantIdx), evaluated each edge:
  - Voluntary release: Req[owner]=0 releases the grant.
  - Forced release: HoldCnt == HOLD_MAX-1, Lock[owner]=0 and any other Req bit set. PreemptCnt increments unless already 255.
  - Otherwise: stay, HoldCnt += 1, saturating at HOLD_MAX-1.
  - At HOLD_MAX-1 with no other requester or Lock[owner]=1: keep the grant, no preemption.
- On release without the feature: arbitrate in the same edge, excluding the owner. If another requester exists, hand off directly (Grant switches in one cycle, HoldCnt=0). If none, Grant=0 and state = IDLE.
- A released owner that still requests is re-granted only after every other pending requester has been served once.
- Req and Lock changes for non-owners never disturb the current grant.
- Out-of-range indices (NREQ < 2**IDX_W) are never granted.
- Grant is always 0 or exactly one-hot. GrantValid = |Grant.

Optional Feature:
ARB_TURNAROUND_EN.
- Defined: every release goes to TURN for exactly one cycle with Grant=0 and GrantValid=0, then arbitrates as in IDLE (Grant is zero for 1 cycle). This gives the shared unit a dead cycle for its registered outputs to settle between owners.
- Undefined: TURN is not compiled in and handoff is direct, as described above.

Test Plan:
- Reset mid-grant: Req=4'b0010 granted, assert Reset for 3 ns between edges -> Grant=0, GrantIdx=0, PreemptCnt=0 immediately. After release, Req=4'b0010 -> Grant=4'b0010 one edge later.
- Round robin: Req held at 4'b1011, each owner drops Req for 1 cycle after its grant, then re-raises -> grant order idx 0,1,3,0,1,3.
- Forced release: HOLD_MAX=8, Req=4'b0011 held, Lock=0 -> idx0 holds 8 cycles, then Grant=4'b0010 (direct) and PreemptCnt=1. After 8 more cycles, idx0 is granted and PreemptCnt=2.
- Lock exemption: same as above with Lock=4'b0001 -> idx0 holds indefinitely (checked for 40 cycles) and PreemptCnt stays 0. Dropping Lock[0] -> release on the next edge once HoldCnt=7.
- Single requester: Req=4'b0100 for 30 cycles -> Grant=4'b0100 continuously, no preemption. Req drops -> Grant=0 one edge later.
- ARB_TURNAROUND_EN defined: handoff 0->1 shows exactly one cycle of Grant=0 and GrantValid=0. PreemptCnt saturates at 255 after 300 forced releases.
